// File: rtl/mux_pipeline_stream.sv
// Registered N:1 multiplexer tree with a valid/ready stream handshake.
// Each stage carries its partial select results plus the full select, an error flag and a valid bit.
module mux_pipeline_stream #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned INPUT_COUNT = 8,
    parameter int unsigned RADIX       = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WIDTH*INPUT_COUNT-1:0]     in_data,
    input  logic [$clog2(INPUT_COUNT)-1:0]   in_sel,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [WIDTH-1:0]                 out_data,
    output logic [$clog2(INPUT_COUNT)-1:0]   out_sel,
    output logic                             out_err,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam int unsigned SEL_W  = $clog2(INPUT_COUNT);
    localparam int unsigned RS     = $clog2(RADIX);
    localparam int unsigned STAGES = (SEL_W + RS - 1) / RS;

    // Number of words feeding stage k (lanes for k = 0, previous-stage nodes otherwise).
    function automatic int unsigned leaves_at(input int unsigned k);
        int unsigned n;
        n = INPUT_COUNT;
        for (int unsigned i = 0; i < k; i++) begin
            n = (n + RADIX - 1) / RADIX;
        end
        return n;
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned N_IN  = leaves_at(k);
        localparam int unsigned N_OUT = leaves_at(k + 1);
        localparam int unsigned N_PAD = N_OUT * RADIX;
        localparam int unsigned SHIFT = k * RS;

        logic [N_IN*WIDTH-1:0]  w_src_data;
        logic [SEL_W-1:0]       w_src_sel;
        logic                   w_src_err;
        logic                   w_src_valid;
        logic                   w_down_ready;
        logic                   w_ready;
        logic [N_PAD*WIDTH-1:0] w_pad_data;
        logic [RS-1:0]          w_digit;
        logic [N_OUT*WIDTH-1:0] w_next_data;

        logic [N_OUT*WIDTH-1:0] r_data;
        logic [SEL_W-1:0]       r_sel;
        logic                   r_err;
        logic                   r_valid;

        if (k == 0) begin : g_head
            assign w_src_data  = in_data;
            assign w_src_sel   = in_sel;
            assign w_src_err   = 32'(in_sel) >= INPUT_COUNT;
            assign w_src_valid = in_valid;
        end else begin : g_tail
            assign w_src_data  = g_stage[k-1].r_data;
            assign w_src_sel   = g_stage[k-1].r_sel;
            assign w_src_err   = g_stage[k-1].r_err;
            assign w_src_valid = g_stage[k-1].r_valid;
        end

        if (k == STAGES - 1) begin : g_last
            assign w_down_ready = out_ready;
        end else begin : g_mid
            assign w_down_ready = g_stage[k+1].w_ready;
        end

        // Missing leaves/children zero-extend; select bits past SEL_W shift in as 0.
        assign w_pad_data = (N_PAD*WIDTH)'(w_src_data);
        assign w_digit    = RS'(w_src_sel >> SHIFT);
        assign w_ready    = !r_valid || w_down_ready;

        always_comb begin
            w_next_data = '0;
            for (int unsigned j = 0; j < N_OUT; j++) begin
                for (int unsigned m = 0; m < RADIX; m++) begin
                    if (w_digit == RS'(m)) begin
                        w_next_data[j*WIDTH +: WIDTH] = w_pad_data[(j*RADIX+m)*WIDTH +: WIDTH];
                    end
                end
            end
            if ((k == STAGES - 1) && w_src_err) begin
                w_next_data = '0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_data  <= '0;
                r_sel   <= '0;
                r_err   <= 1'b0;
                r_valid <= 1'b0;
            end else if (w_ready) begin
                r_data  <= w_next_data;
                r_sel   <= w_src_sel;
                r_err   <= w_src_err;
                r_valid <= w_src_valid;
            end
        end
    end

    assign in_ready  = g_stage[0].w_ready;
    assign out_data  = g_stage[STAGES-1].r_data;
    assign out_sel   = g_stage[STAGES-1].r_sel;
    assign out_err   = g_stage[STAGES-1].r_err;
    assign out_valid = g_stage[STAGES-1].r_valid;

endmodule
